ap_line_wb: RTL and testbench

- Parametrised tape-pointer/data-cell line for the DekatronPC datapath.
- Holds the address pointer (AP) and a write-back cache of the addressed data cell, both as BCD up/down counters with wrap-around.
- New in this generation:
  - digit widths and top values are parameters;
  - a multi-step repeat count per request, so compressed "+++"/">>>" runs finish in one transaction;
  - a dirty flag, so RAM is written only when the cell was modified;
  - an explicit Flush.
- Sits between the instruction sequencer (requests) and the data RAM.

---
 rtl/ap_line_wb.sv | 130 +++++++++++++
 tb/tb_ap_line_wb.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/ap_line_wb.sv
// ap_line_wb: tape pointer plus write-back cached data cell, both BCD wrap-around counters
module ap_line_wb_bcd #(
  parameter int D = 1,
  parameter logic [4*D-1:0] TOP = '1
) (
  input  logic [4*D-1:0] v_i,
  input  logic           dec_i,
  output logic [4*D-1:0] q_o
);
  always_comb begin
    logic       c;
    logic [3:0] d;
    c = 1'b1;
    d = '0;
    q_o = v_i;
    for (int i = 0; i < D; i++) begin
      d = v_i[4*i+:4];
      if (c) begin
        q_o[4*i+:4] = dec_i ? ((d == 4'd0) ? 4'd9 : d - 4'd1) : ((d == 4'd9) ? 4'd0 : d + 4'd1);
        c = dec_i ? (d == 4'd0) : (d == 4'd9);
      end
    end
    if (!dec_i && v_i == TOP) q_o = '0;
    if (dec_i && v_i == '0) q_o = TOP;
  end
endmodule

module ap_line_wb #(
  parameter int AP_DIGITS   = 5,
  parameter int DATA_DIGITS = 3,
  parameter int STEP_DIGITS = 1,
  parameter logic [4*AP_DIGITS-1:0]   AP_TOP   = 20'h29999,
  parameter logic [4*DATA_DIGITS-1:0] DATA_TOP = 12'h255
) (
  input  logic                     Clk,
  input  logic                     Rst_n,
  input  logic                     ApRequest,
  input  logic                     DataRequest,
  input  logic                     Dec,
  input  logic                     Zero,
  input  logic [4*STEP_DIGITS-1:0] Steps,
  input  logic                     Flush,
  output logic                     Ready,
  output logic [4*AP_DIGITS-1:0]   Address,
  output logic [4*DATA_DIGITS-1:0] Data,
  output logic                     DataZero,
  output logic                     ApZero,
  output logic [4*DATA_DIGITS-1:0] RamDataIn,
  input  logic [4*DATA_DIGITS-1:0] RamDataOut,
  output logic                     RamWE,
  output logic                     RamCS
);
  localparam int AW = 4*AP_DIGITS;
  localparam int DW = 4*DATA_DIGITS;
  localparam int SW = 4*STEP_DIGITS;
  typedef enum logic [2:0] {IDLE, LOAD, WB, COUNT_AP, COUNT_D} state_t;
  state_t        state_q;
  logic [AW-1:0] ap_q, ap_d;
  logic [DW-1:0] cache_q, cache_d;
  logic [SW-1:0] cnt_q, cnt_d, n_steps;
  logic          valid_q, dirty_q, dec_q, zero_q, wb_ap_q, last;
  ap_line_wb_bcd #(.D(AP_DIGITS), .TOP(AP_TOP)) u_ap (.v_i(ap_q), .dec_i(dec_q), .q_o(ap_d));
  ap_line_wb_bcd #(.D(DATA_DIGITS), .TOP(DATA_TOP)) u_data (.v_i(cache_q), .dec_i(dec_q), .q_o(cache_d));
  ap_line_wb_bcd #(.D(STEP_DIGITS), .TOP({STEP_DIGITS{4'h9}})) u_cnt (.v_i(cnt_q), .dec_i(1'b1), .q_o(cnt_d));
  assign n_steps   = (Steps == '0) ? SW'(1) : Steps;
  assign last      = zero_q || cnt_q == SW'(1);
  assign Ready     = (state_q == IDLE) & ~ApRequest & ~DataRequest & ~Flush;
  assign Address   = ap_q;
  assign Data      = valid_q ? cache_q : RamDataOut;
  assign DataZero  = ~|Data;
  assign ApZero    = ~|Address;
  assign RamDataIn = cache_q;
  assign RamWE     = state_q == WB;
  assign RamCS     = Rst_n;
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= IDLE;
      ap_q    <= '0;
      cache_q <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      dirty_q <= 1'b0;
      dec_q   <= 1'b0;
      zero_q  <= 1'b0;
      wb_ap_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (ApRequest || DataRequest) begin
            dec_q   <= Dec;
            zero_q  <= Zero;
            cnt_q   <= n_steps;
            wb_ap_q <= ApRequest;
          end
          if (ApRequest) begin
            if (!dirty_q) valid_q <= 1'b0;
            state_q <= dirty_q ? WB : COUNT_AP;
          end else if (DataRequest) begin
            state_q <= valid_q ? COUNT_D : LOAD;
          end else if (Flush && dirty_q) begin
            wb_ap_q <= 1'b0;
            state_q <= WB;
          end
        end
        LOAD: begin
          cache_q <= RamDataOut;
          valid_q <= 1'b1;
          state_q <= COUNT_D;
        end
        WB: begin
          dirty_q <= 1'b0;
          if (wb_ap_q) valid_q <= 1'b0;
          state_q <= wb_ap_q ? COUNT_AP : IDLE;
        end
        COUNT_AP: begin
          ap_q    <= zero_q ? '0 : ap_d;
          cnt_q   <= cnt_d;
          state_q <= last ? IDLE : COUNT_AP;
        end
        COUNT_D: begin
          cache_q <= zero_q ? '0 : cache_d;
          dirty_q <= 1'b1;
          cnt_q   <= cnt_d;
          state_q <= last ? IDLE : COUNT_D;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ap_line_wb.sv
// tb_ap_line_wb: directed checks of pointer/cell stepping, write-back, flush and reset abort
module tb_ap_line_wb;
  logic        Clk = 1'b0, Rst_n = 1'b0;
  logic        ApRequest = 0, DataRequest = 0, Dec = 0, Zero = 0, Flush = 0;
  logic [3:0]  Steps = '0;
  logic        Ready, DataZero, ApZero, RamWE, RamCS;
  logic [19:0] Address;
  logic [11:0] Data, RamDataIn, RamDataOut = '0;
  int n_chk = 0, n_fail = 0, we_cnt = 0, lat;
  logic [19:0] we_addr;
  logic [11:0] we_data;

  ap_line_wb dut (
    .Clk(Clk), .Rst_n(Rst_n), .ApRequest(ApRequest), .DataRequest(DataRequest),
    .Dec(Dec), .Zero(Zero), .Steps(Steps), .Flush(Flush), .Ready(Ready),
    .Address(Address), .Data(Data), .DataZero(DataZero), .ApZero(ApZero),
    .RamDataIn(RamDataIn), .RamDataOut(RamDataOut), .RamWE(RamWE), .RamCS(RamCS)
  );

  always #5 Clk = ~Clk;

  always @(negedge Clk) if (RamWE) begin
    we_cnt  = we_cnt + 1;
    we_addr = Address;
    we_data = RamDataIn;
  end

  task automatic issue(input logic ap, input logic dr, input logic fl, input logic dc,
                       input logic zr, input logic [3:0] st, output int l);
    @(negedge Clk);
    ApRequest = ap; DataRequest = dr; Flush = fl; Dec = dc; Zero = zr; Steps = st;
    @(posedge Clk);
    l = 1;
    #1 ApRequest = 0; DataRequest = 0; Flush = 0;
    #1;
    while (!Ready && l < 100) begin
      @(posedge Clk);
      #2 l++;
    end
  endtask

  task automatic test_reset;
    #12;
    n_chk += 5;
    if (RamWE !== 1'b0) begin n_fail++; $display("FAIL reset_we got %b want 0", RamWE); end
    if (RamCS !== 1'b0) begin n_fail++; $display("FAIL reset_cs got %b want 0", RamCS); end
    if (Address !== 20'h0) begin n_fail++; $display("FAIL reset_addr got %h want 0", Address); end
    if (Ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", Ready); end
    if (Data !== 12'h000) begin n_fail++; $display("FAIL reset_data got %h want 000", Data); end
    @(negedge Clk) Rst_n = 1'b1;
    @(negedge Clk);
    n_chk++;
    if (RamCS !== 1'b1) begin n_fail++; $display("FAIL run_cs got %b want 1", RamCS); end
  endtask

  task automatic test_load_count;
    RamDataOut = 12'h007;
    issue(0, 1, 0, 0, 0, 4'd3, lat);
    RamDataOut = 12'h123;
    #1;
    n_chk += 3;
    if (lat !== 5) begin n_fail++; $display("FAIL load_lat got %0d want 5", lat); end
    if (Data !== 12'h010) begin n_fail++; $display("FAIL load_data got %h want 010", Data); end
    if (we_cnt !== 0) begin n_fail++; $display("FAIL load_we got %0d want 0", we_cnt); end
  endtask

  task automatic test_ap_wb;
    issue(1, 0, 0, 0, 0, 4'd2, lat);
    n_chk += 6;
    if (lat !== 4) begin n_fail++; $display("FAIL apwb_lat got %0d want 4", lat); end
    if (we_cnt !== 1) begin n_fail++; $display("FAIL apwb_we got %0d want 1", we_cnt); end
    if (we_addr !== 20'h0) begin n_fail++; $display("FAIL apwb_addr got %h want 0", we_addr); end
    if (we_data !== 12'h010) begin n_fail++; $display("FAIL apwb_wdata got %h want 010", we_data); end
    if (Address !== 20'h00002) begin n_fail++; $display("FAIL apwb_ap got %h want 00002", Address); end
    if (Data !== 12'h123) begin n_fail++; $display("FAIL apwb_follow got %h want 123", Data); end
  endtask

  task automatic test_wrap;
    issue(0, 1, 0, 0, 1, 4'd4, lat);
    n_chk += 3;
    if (lat !== 3) begin n_fail++; $display("FAIL zero_lat got %0d want 3", lat); end
    if (Data !== 12'h000) begin n_fail++; $display("FAIL zero_data got %h want 000", Data); end
    if (DataZero !== 1'b1) begin n_fail++; $display("FAIL zero_flag got %b want 1", DataZero); end
    issue(0, 1, 0, 1, 0, 4'd1, lat);
    n_chk += 3;
    if (lat !== 2) begin n_fail++; $display("FAIL dwrap_lat got %0d want 2", lat); end
    if (Data !== 12'h255) begin n_fail++; $display("FAIL dwrap_data got %h want 255", Data); end
    if (DataZero !== 1'b0) begin n_fail++; $display("FAIL dwrap_flag got %b want 0", DataZero); end
    issue(1, 0, 0, 1, 0, 4'd3, lat);
    n_chk += 5;
    if (lat !== 5) begin n_fail++; $display("FAIL awrap_lat got %0d want 5", lat); end
    if (we_cnt !== 2) begin n_fail++; $display("FAIL awrap_we got %0d want 2", we_cnt); end
    if (we_addr !== 20'h00002 || we_data !== 12'h255) begin
      n_fail++; $display("FAIL awrap_wb got %h/%h want 00002/255", we_addr, we_data);
    end
    if (Address !== 20'h29999) begin n_fail++; $display("FAIL awrap_ap got %h want 29999", Address); end
    if (ApZero !== 1'b0) begin n_fail++; $display("FAIL awrap_flag got %b want 0", ApZero); end
    issue(1, 0, 0, 0, 0, 4'd1, lat);
    n_chk += 4;
    if (lat !== 2) begin n_fail++; $display("FAIL atop_lat got %0d want 2", lat); end
    if (Address !== 20'h0) begin n_fail++; $display("FAIL atop_ap got %h want 0", Address); end
    if (ApZero !== 1'b1) begin n_fail++; $display("FAIL atop_flag got %b want 1", ApZero); end
    if (we_cnt !== 2) begin n_fail++; $display("FAIL atop_we got %0d want 2", we_cnt); end
  endtask

  task automatic test_flush;
    RamDataOut = 12'h042;
    issue(0, 1, 0, 0, 0, 4'd0, lat);
    n_chk += 2;
    if (lat !== 3) begin n_fail++; $display("FAIL s0_lat got %0d want 3", lat); end
    if (Data !== 12'h043) begin n_fail++; $display("FAIL s0_data got %h want 043", Data); end
    issue(0, 0, 1, 0, 0, 4'd0, lat);
    n_chk += 4;
    if (lat !== 2) begin n_fail++; $display("FAIL flush_lat got %0d want 2", lat); end
    if (we_cnt !== 3) begin n_fail++; $display("FAIL flush_we got %0d want 3", we_cnt); end
    if (we_data !== 12'h043) begin n_fail++; $display("FAIL flush_wdata got %h want 043", we_data); end
    if (Data !== 12'h043) begin n_fail++; $display("FAIL flush_data got %h want 043", Data); end
    issue(0, 0, 1, 0, 0, 4'd0, lat);
    n_chk += 2;
    if (lat !== 1) begin n_fail++; $display("FAIL flush2_lat got %0d want 1", lat); end
    if (we_cnt !== 3) begin n_fail++; $display("FAIL flush2_we got %0d want 3", we_cnt); end
    issue(1, 0, 0, 0, 0, 4'd1, lat);
    n_chk += 3;
    if (lat !== 2) begin n_fail++; $display("FAIL clean_lat got %0d want 2", lat); end
    if (we_cnt !== 3) begin n_fail++; $display("FAIL clean_we got %0d want 3", we_cnt); end
    if (Address !== 20'h00001) begin n_fail++; $display("FAIL clean_ap got %h want 00001", Address); end
  endtask

  task automatic test_priority;
    issue(0, 1, 0, 0, 0, 4'd2, lat);
    n_chk++;
    if (Data !== 12'h044) begin n_fail++; $display("FAIL pre_data got %h want 044", Data); end
    issue(1, 1, 0, 0, 1, 4'd5, lat);
    RamDataOut = 12'h099;
    #1;
    n_chk += 5;
    if (lat !== 3) begin n_fail++; $display("FAIL prio_lat got %0d want 3", lat); end
    if (Address !== 20'h0) begin n_fail++; $display("FAIL prio_ap got %h want 0", Address); end
    if (we_cnt !== 4) begin n_fail++; $display("FAIL prio_we got %0d want 4", we_cnt); end
    if (we_data !== 12'h044 || we_addr !== 20'h00001) begin
      n_fail++; $display("FAIL prio_wb got %h/%h want 00001/044", we_addr, we_data);
    end
    if (Data !== 12'h099) begin n_fail++; $display("FAIL prio_data got %h want 099", Data); end
  endtask

  task automatic test_reset_wb;
    issue(0, 1, 0, 0, 0, 4'd1, lat);
    n_chk++;
    if (Data !== 12'h100) begin n_fail++; $display("FAIL carry_data got %h want 100", Data); end
    @(negedge Clk);
    ApRequest = 1; Steps = 4'd7; Dec = 0; Zero = 0;
    @(posedge Clk);
    #1 ApRequest = 0;
    n_chk++;
    if (RamWE !== 1'b1) begin n_fail++; $display("FAIL rwb_we_hi got %b want 1", RamWE); end
    Rst_n = 1'b0;
    #1;
    n_chk++;
    if (RamWE !== 1'b0) begin n_fail++; $display("FAIL rwb_we_lo got %b want 0", RamWE); end
    @(negedge Clk) Rst_n = 1'b1;
    RamDataOut = 12'h123;
    #1;
    n_chk += 4;
    if (Address !== 20'h0) begin n_fail++; $display("FAIL rwb_ap got %h want 0", Address); end
    if (Data !== 12'h123) begin n_fail++; $display("FAIL rwb_data got %h want 123", Data); end
    if (Ready !== 1'b1) begin n_fail++; $display("FAIL rwb_ready got %b want 1", Ready); end
    if (we_cnt !== 4) begin n_fail++; $display("FAIL rwb_we_cnt got %0d want 4", we_cnt); end
  endtask

  initial begin
    test_reset;
    test_load_count;
    test_ap_wb;
    test_wrap;
    test_flush;
    test_priority;
    test_reset_wb;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
